// File: rtl/patch_row_reducer_n.sv
// patch_row_reducer_n
//   Matches one configured patch row against a multi-lane pixel stream,
//   weights each matched pixel by its per-column coefficient and accumulates
//   a single signed row sum, then offers it to the owning patch reducer over
//   a valid/ack handshake.
//
//   Build option: define PATCH_ROW_REDUCER_SATURATE_EN for a clamping
//   accumulator with a sticky sum_sat flag; otherwise the accumulator wraps
//   and sum_sat is tied low.
//
//   Ports
//     dram_clk, reset_n      clock, synchronous active-low reset
//     init / cfg_ready       configuration strobe / accepted only in IDLE
//     cfg_row, cfg_start_col patch row and first column
//     cfg_owner              destination reducer, echoed on owner_reducer
//     cfg_weights            PATCH_SIZE signed weights, weight i at [i*W_WIDTH +: W_WIDTH]
//     ds_valid, n_row, l_col beat qualifier, beat row, column of lane 0
//     ds                     N_PIX unsigned pixels, lane k at [k*DS_WIDTH +: DS_WIDTH]
//     sum_valid / sum_ack    result handshake
//     sum, sum_partial       row sum, patch ended on a row change
//     sum_sat                accumulator clamped during this patch

// Per-lane column match and weighted product (combinational).
module patch_row_reducer_lane #(
    parameter int DS_WIDTH   = 16,
    parameter int W_WIDTH    = 16,
    parameter int PATCH_SIZE = 4,
    parameter int N_COL_SIZE = 11,
    parameter int PROD_W     = 33
) (
    input  logic                          en,
    input  logic [N_COL_SIZE:0]           col,        // widened so lane offsets never wrap
    input  logic [N_COL_SIZE-1:0]         start_col,
    input  logic [DS_WIDTH-1:0]           pix,
    input  logic [PATCH_SIZE*W_WIDTH-1:0] weights,
    input  logic [PATCH_SIZE-1:0]         seen,
    output logic [PATCH_SIZE-1:0]         hit_col,
    output logic [PROD_W-1:0]             prod
);
    localparam int COL_W = N_COL_SIZE + 1;

    logic [COL_W-1:0]          off;
    logic signed [W_WIDTH-1:0] w;
    logic signed [PROD_W-1:0]  p;

    always_comb begin
        off     = col - {1'b0, start_col};
        hit_col = '0;
        w       = '0;
        for (int i = 0; i < PATCH_SIZE; i++) begin
            if (en && (col >= {1'b0, start_col}) && (off == COL_W'(i)) && !seen[i]) begin
                hit_col[i] = 1'b1;
                w          = weights[i*W_WIDTH +: W_WIDTH];
            end
        end
        // unmatched lanes carry a zero weight, so their product is zero
        p    = $signed({1'b0, pix}) * w;
        prod = p;
    end
endmodule

module patch_row_reducer_n #(
    parameter int N_PIX           = 2,
    parameter int PATCH_SIZE      = 4,
    parameter int DS_WIDTH        = 16,
    parameter int W_WIDTH         = 16,
    parameter int SUM_WIDTH       = 40,
    parameter int N_COL_SIZE      = 11,
    parameter int N_ROW_SIZE      = 11,
    parameter int N_PATCH_REDUCER = 16
) (
    input  logic                               dram_clk,
    input  logic                               reset_n,
    input  logic                               init,
    output logic                               cfg_ready,
    input  logic [N_ROW_SIZE-1:0]              cfg_row,
    input  logic [N_COL_SIZE-1:0]              cfg_start_col,
    input  logic [$clog2(N_PATCH_REDUCER)-1:0] cfg_owner,
    input  logic [PATCH_SIZE*W_WIDTH-1:0]      cfg_weights,
    input  logic                               ds_valid,
    input  logic [N_ROW_SIZE-1:0]              n_row,
    input  logic [N_COL_SIZE-1:0]              l_col,
    input  logic [N_PIX*DS_WIDTH-1:0]          ds,
    output logic                               sum_valid,
    input  logic                               sum_ack,
    output logic [SUM_WIDTH-1:0]               sum,
    output logic [$clog2(N_PATCH_REDUCER)-1:0] owner_reducer,
    output logic                               sum_partial,
    output logic                               sum_sat
);
    localparam int COL_W  = N_COL_SIZE + 1;
    localparam int PROD_W = DS_WIDTH + W_WIDTH + 1;
    localparam int TREE_W = PROD_W + $clog2(N_PIX) + 1;
    // wide enough to hold acc + lane sum without loss, so both the wrap and
    // the clamp decisions are exact
    localparam int EXT_W  = ((TREE_W > SUM_WIDTH) ? TREE_W : SUM_WIDTH) + 1;
    localparam int PIPE   = 2;   // registered stages ahead of the accumulator

    typedef enum logic [1:0] {IDLE, MATCH, DRAIN, HOLD} state_t;

    state_t                          state;
    logic [1:0]                      drain_cnt;
    logic [N_ROW_SIZE-1:0]           row_q;
    logic [N_COL_SIZE-1:0]           start_q;
    logic [PATCH_SIZE*W_WIDTH-1:0]   w_q;
    logic [PATCH_SIZE-1:0]           seen_q;
    logic [PIPE:1]                   vld_pipe;
    logic [N_PIX-1:0][PROD_W-1:0]    prod_q;
    logic signed [TREE_W-1:0]        tree_q;
    logic signed [SUM_WIDTH-1:0]     acc_q;

    logic                            match_en;
    logic [N_PIX-1:0][PATCH_SIZE-1:0] lane_hit;
    logic [N_PIX-1:0][PROD_W-1:0]    lane_prod;
    logic [PATCH_SIZE-1:0]           hit_all;
    logic [PATCH_SIZE-1:0]           seen_next;
    logic signed [TREE_W-1:0]        tree_sum;
    logic signed [EXT_W-1:0]         acc_ext;
    logic signed [SUM_WIDTH-1:0]     acc_next;

`ifdef PATCH_ROW_REDUCER_SATURATE_EN
    localparam logic signed [EXT_W-1:0] SUM_MAX = {{(EXT_W-SUM_WIDTH+1){1'b0}}, {(SUM_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SUM_MIN = {{(EXT_W-SUM_WIDTH+1){1'b1}}, {(SUM_WIDTH-1){1'b0}}};
    logic sat_hit;
    logic sat_q;
    assign sum_sat = sat_q;
`else
    assign sum_sat = 1'b0;
`endif

    assign match_en = ds_valid && (state == MATCH) && (n_row == row_q);

    for (genvar k = 0; k < N_PIX; k++) begin : g_lane
        patch_row_reducer_lane #(
            .DS_WIDTH  (DS_WIDTH),
            .W_WIDTH   (W_WIDTH),
            .PATCH_SIZE(PATCH_SIZE),
            .N_COL_SIZE(N_COL_SIZE),
            .PROD_W    (PROD_W)
        ) u_lane (
            .en       (match_en),
            .col      ({1'b0, l_col} + COL_W'(k)),
            .start_col(start_q),
            .pix      (ds[k*DS_WIDTH +: DS_WIDTH]),
            .weights  (w_q),
            .seen     (seen_q),
            .hit_col  (lane_hit[k]),
            .prod     (lane_prod[k])
        );
    end

    always_comb begin
        hit_all  = '0;
        tree_sum = '0;
        for (int k = 0; k < N_PIX; k++) begin
            hit_all  = hit_all | lane_hit[k];
            tree_sum = tree_sum + TREE_W'($signed(prod_q[k]));
        end
        seen_next = seen_q | hit_all;
        acc_ext   = EXT_W'(acc_q) + EXT_W'(tree_q);
        acc_next  = acc_ext[SUM_WIDTH-1:0];
`ifdef PATCH_ROW_REDUCER_SATURATE_EN
        sat_hit = 1'b0;
        if (acc_ext > SUM_MAX) begin
            acc_next = SUM_MAX[SUM_WIDTH-1:0];
            sat_hit  = 1'b1;
        end else if (acc_ext < SUM_MIN) begin
            acc_next = SUM_MIN[SUM_WIDTH-1:0];
            sat_hit  = 1'b1;
        end
`endif
    end

    always_ff @(posedge dram_clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            row_q         <= '0;
            start_q       <= '0;
            w_q           <= '0;
            seen_q        <= '0;
            vld_pipe      <= '0;
            prod_q        <= '0;
            tree_q        <= '0;
            acc_q         <= '0;
            cfg_ready     <= 1'b1;
            sum_valid     <= 1'b0;
            owner_reducer <= '0;
            sum_partial   <= 1'b0;
`ifdef PATCH_ROW_REDUCER_SATURATE_EN
            sat_q         <= 1'b0;
`endif
        end else begin
            // pipeline runs freely; lanes only produce non-zero work in MATCH
            vld_pipe[1] <= |hit_all;
            prod_q      <= lane_prod;
            vld_pipe[2] <= vld_pipe[1];
            tree_q      <= tree_sum;
            if (vld_pipe[2]) begin
                acc_q <= acc_next;
`ifdef PATCH_ROW_REDUCER_SATURATE_EN
                if (sat_hit) sat_q <= 1'b1;
`endif
            end

            case (state)
                IDLE: begin
                    if (init) begin
                        state         <= MATCH;
                        row_q         <= cfg_row;
                        start_q       <= cfg_start_col;
                        w_q           <= cfg_weights;
                        owner_reducer <= cfg_owner;
                        seen_q        <= '0;
                        vld_pipe      <= '0;
                        prod_q        <= '0;
                        tree_q        <= '0;
                        acc_q         <= '0;
                        sum_partial   <= 1'b0;
                        cfg_ready     <= 1'b0;
`ifdef PATCH_ROW_REDUCER_SATURATE_EN
                        sat_q         <= 1'b0;
`endif
                    end
                end
                MATCH: begin
                    drain_cnt <= '0;
                    if (ds_valid) begin
                        seen_q <= seen_next;
                        if (&seen_next) begin
                            state <= DRAIN;
                        end else if ((n_row != row_q) && (|seen_q)) begin
                            state       <= DRAIN;
                            sum_partial <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // four edges after the completing beat: the last product
                    // lands in the accumulator two edges in, HOLD on the fourth
                    if (drain_cnt == 2'd3) begin
                        state     <= HOLD;
                        sum_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                HOLD: begin
                    if (sum_ack) begin
                        state     <= IDLE;
                        sum_valid <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sum = acc_q;
endmodule
